// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for a Y86-64 style pipeline.
// Decodes the memory class of an instruction, issues one request and reports completion.
module mem_access_ctrl #(
  parameter int unsigned ADDR_LIMIT = 1024,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valA,
  input  logic [63:0] valB,
  input  logic [63:0] valE,
  input  logic [63:0] valP,
  output logic        busy,
  output logic        done,
  output logic [63:0] valM,
  output logic        dmem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned WAIT_W = 8;

  localparam logic [3:0] IC_RMMOVQ = 4'h4;
  localparam logic [3:0] IC_MRMOVQ = 4'h5;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSHQ  = 4'hA;
  localparam logic [3:0] IC_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_req;
  logic                r_we;
  logic                r_err;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_valm;
  logic [WAIT_W-1:0]   r_wait;

  logic                w_is_rd;
  logic                w_is_wr;
  logic                w_is_mem;
  logic                w_bad;
  logic                w_timeout;
  logic [DATA_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;

  // Instruction decode: memory class, effective address and store data.
  always_comb begin
    w_is_rd = 1'b0;
    w_is_wr = 1'b0;
    w_addr  = valE;
    w_wdata = valA;
    case (icode)
      IC_RMMOVQ, IC_PUSHQ: w_is_wr = 1'b1;
      IC_CALL: begin
        w_is_wr = 1'b1;
        w_wdata = valP;
      end
      IC_MRMOVQ: w_is_rd = 1'b1;
      IC_POPQ, IC_RET: begin
        w_is_rd = 1'b1;
        w_addr  = valB;
      end
      default: ;
    endcase
  end

  assign w_is_mem  = w_is_rd | w_is_wr;
  assign w_bad     = w_is_mem && (w_addr >= DATA_W'(ADDR_LIMIT));
  // The current REQ cycle is the TIMEOUT-th one without an ack.
  assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

  // Controller FSM with all outputs held in registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_valm  <= '0;
      r_wait  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_we    <= w_is_wr;
            r_err   <= w_bad;
            r_wait  <= '0;
            r_busy  <= 1'b1;
            if (w_is_mem && !w_bad) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // An ack in the timeout cycle still counts as a normal completion.
          if (mem_ack) begin
            r_req   <= 1'b0;
            r_state <= S_DONE;
            r_done  <= 1'b1;
            if (!r_we) begin
              r_valm <= mem_rdata;
            end
          end else if (w_timeout) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign valM       = r_valm;
  assign dmem_error = r_err;
  assign mem_req    = r_req;
  assign mem_we     = r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// instructions checked against a transaction-level reference model.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_LIMIT = 1024;
  localparam int unsigned TIMEOUT    = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  icode;
  logic [63:0] valA, valB, valE, valP;
  logic        busy, done, dmem_error, mem_req, mem_we, mem_ack;
  logic [63:0] valM, mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_valm = 64'd0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_LIMIT(ADDR_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode),
    .valA(valA), .valB(valB), .valE(valE), .valP(valP),
    .busy(busy), .done(done), .valM(valM), .dmem_error(dmem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          req_cycles;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    bit          stable;
    int          done_lat;
    int          done_cnt;
    logic        err;
    logic [63:0] valm;
    logic        busy_after;
    logic        err_after;
    logic [63:0] valm_after;
    bit          finished;
  } obs_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction, plays the memory side and records what the DUT did.
  task automatic run_op(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] e, input logic [63:0] p, input int ack_at,
                        input logic [63:0] rdata, input bit hold_start, input bit ack_in_done,
                        output obs_t o);
    o = '{default: 0};
    o.stable = 1'b1;
    icode = ic; valA = a; valB = b; valE = e; valP = p;
    start = 1'b1;
    step();
    if (!hold_start) start = 1'b0;
    else begin
      icode = 4'h5; valE = 64'h8; valB = 64'h8;
    end
    for (int cyc = 1; cyc <= 60; cyc++) begin
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (o.req_cycles == 0) begin
          o.addr = mem_addr; o.we = mem_we; o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr || mem_we !== o.we || mem_wdata !== o.wdata) begin
          o.stable = 1'b0;
        end
        if (o.req_cycles == ack_at) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end
        o.req_cycles++;
      end
      if (done === 1'b1) begin
        if (o.done_cnt == 0) begin
          o.done_lat = cyc; o.err = dmem_error; o.valm = valM;
        end
        o.done_cnt++;
        if (ack_in_done) begin
          mem_ack = 1'b1; mem_rdata = ~rdata;
        end
      end else if (o.done_cnt > 0) begin
        o.busy_after = busy; o.err_after = dmem_error; o.valm_after = valM;
        o.finished = 1'b1;
        start = 1'b0;
        break;
      end
      step();
    end
    start = 1'b0;
    mem_ack = 1'b0;
  endtask

  // Reference: classify the instruction from the ISA tables.
  function automatic void model(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] e, input logic [63:0] p,
                                output int kind, output logic [63:0] addr,
                                output logic [63:0] wdata, output bit bad);
    kind  = (ic inside {4'h5, 4'hB, 4'h9}) ? 1 : (ic inside {4'h4, 4'hA, 4'h8}) ? 2 : 0;
    addr  = (ic == 4'hB || ic == 4'h9) ? b : e;
    wdata = (ic == 4'h8) ? p : a;
    bad   = (kind != 0) && (addr >= 64'(ADDR_LIMIT));
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks++;
    if ({busy, done, mem_req, mem_we, dmem_error} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {busy, done, mem_req, mem_we, dmem_error});
    end
    checks++;
    if ({mem_addr, mem_wdata, valM} !== 192'd0) begin
      errors++; $display("FAIL reset_data got addr=%h wdata=%h valM=%h exp 0", mem_addr, mem_wdata, valM);
    end
    reset = 1'b0;
    step();
    exp_valm = 64'd0;
  endtask

  task automatic test_mrmovq();
    obs_t o;
    run_op(4'h5, 64'h0, 64'h0, 64'h10, 64'h0, 1, 64'hDEAD, 1'b0, 1'b0, o);
    exp_valm = 64'hDEAD;
    checks++;
    if (o.addr !== 64'h10 || o.we !== 1'b0) begin
      errors++; $display("FAIL mrmovq_req got addr=%h we=%b exp 10/0", o.addr, o.we);
    end
    checks++;
    if (o.valm !== 64'hDEAD || o.err !== 1'b0) begin
      errors++; $display("FAIL mrmovq_result got valM=%h err=%b exp dead/0", o.valm, o.err);
    end
    checks++;
    if (o.done_lat != 3 || o.done_cnt != 1) begin
      errors++; $display("FAIL mrmovq_done got lat=%0d cnt=%0d exp 3/1", o.done_lat, o.done_cnt);
    end
  endtask

  task automatic test_call();
    obs_t o;
    run_op(4'h8, 64'h111, 64'h0, 64'h3F8, 64'h2A, 0, 64'hBAD0, 1'b0, 1'b0, o);
    checks++;
    if (o.we !== 1'b1 || o.addr !== 64'h3F8 || o.wdata !== 64'h2A) begin
      errors++; $display("FAIL call_req got we=%b addr=%h wdata=%h exp 1/3f8/2a", o.we, o.addr, o.wdata);
    end
    checks++;
    if (o.valm !== exp_valm || o.done_lat != 2) begin
      errors++; $display("FAIL call_done got valM=%h lat=%0d exp %h/2", o.valm, o.done_lat, exp_valm);
    end
  endtask

  task automatic test_popq();
    obs_t o;
    run_op(4'hB, 64'h0, 64'h20, 64'h28, 64'h0, 0, 64'h5555, 1'b0, 1'b0, o);
    exp_valm = 64'h5555;
    checks++;
    if (o.addr !== 64'h20 || o.valm !== 64'h5555) begin
      errors++; $display("FAIL popq got addr=%h valM=%h exp 20/5555", o.addr, o.valm);
    end
  endtask

  task automatic test_bad_addr();
    obs_t o;
    run_op(4'h4, 64'h9, 64'h0, 64'd1024, 64'h0, 0, 64'h0, 1'b0, 1'b0, o);
    checks++;
    if (o.req_cycles != 0 || o.done_lat != 1) begin
      errors++; $display("FAIL bad_addr_req got req=%0d lat=%0d exp 0/1", o.req_cycles, o.done_lat);
    end
    checks++;
    if (o.err !== 1'b1 || o.err_after !== 1'b1 || o.valm_after !== exp_valm) begin
      errors++; $display("FAIL bad_addr_err got err=%b held=%b valM=%h exp 1/1/%h", o.err, o.err_after, o.valm_after, exp_valm);
    end
    step(); step();
    checks++;
    if (dmem_error !== 1'b1) begin
      errors++; $display("FAIL bad_addr_hold got %b exp 1", dmem_error);
    end
    run_op(4'h5, 64'h0, 64'h0, 64'd1023, 64'h0, 0, 64'h3FF3, 1'b0, 1'b0, o);
    exp_valm = 64'h3FF3;
    checks++;
    if (o.req_cycles != 1 || o.err !== 1'b0 || o.valm !== 64'h3FF3) begin
      errors++; $display("FAIL last_addr got req=%0d err=%b valM=%h exp 1/0/3ff3", o.req_cycles, o.err, o.valm);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_op(4'h9, 64'h0, 64'h40, 64'h0, 64'h0, 99, 64'h0, 1'b0, 1'b0, o);
    checks++;
    if (o.req_cycles != 15 || !o.stable || o.done_lat != 16) begin
      errors++; $display("FAIL timeout_req got req=%0d stable=%0d lat=%0d exp 15/1/16", o.req_cycles, o.stable, o.done_lat);
    end
    checks++;
    if (o.err !== 1'b1 || o.valm !== exp_valm) begin
      errors++; $display("FAIL timeout_err got err=%b valM=%h exp 1/%h", o.err, o.valm, exp_valm);
    end
    run_op(4'h9, 64'h0, 64'h40, 64'h0, 64'h0, 14, 64'h7777, 1'b0, 1'b0, o);
    exp_valm = 64'h7777;
    checks++;
    if (o.req_cycles != 15 || o.err !== 1'b0 || o.valm !== 64'h7777 || o.done_lat != 16) begin
      errors++; $display("FAIL ack_at_limit got req=%0d err=%b valM=%h lat=%0d exp 15/0/7777/16", o.req_cycles, o.err, o.valm, o.done_lat);
    end
  endtask

  task automatic test_ack_ignored();
    obs_t o;
    mem_ack = 1'b1; mem_rdata = 64'hAAAA;
    step();
    mem_ack = 1'b0;
    step();
    checks++;
    if (valM !== exp_valm || busy !== 1'b0) begin
      errors++; $display("FAIL ack_idle got valM=%h busy=%b exp %h/0", valM, busy, exp_valm);
    end
    run_op(4'h5, 64'h0, 64'h0, 64'h18, 64'h0, 2, 64'h1818, 1'b0, 1'b1, o);
    exp_valm = 64'h1818;
    checks++;
    if (o.valm_after !== 64'h1818 || o.busy_after !== 1'b0) begin
      errors++; $display("FAIL ack_done got valM=%h busy=%b exp 1818/0", o.valm_after, o.busy_after);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    run_op(4'h4, 64'h77, 64'h0, 64'h30, 64'h0, 2, 64'h0, 1'b1, 1'b0, o);
    checks++;
    if (o.addr !== 64'h30 || o.we !== 1'b1 || o.wdata !== 64'h77 || !o.stable) begin
      errors++; $display("FAIL hold_start_req got addr=%h we=%b wdata=%h stable=%0d exp 30/1/77/1", o.addr, o.we, o.wdata, o.stable);
    end
    checks++;
    if (o.done_cnt != 1 || o.busy_after !== 1'b0 || !o.finished || o.req_cycles != 3) begin
      errors++; $display("FAIL hold_start_done got cnt=%0d busy=%b fin=%0d req=%0d exp 1/0/1/3", o.done_cnt, o.busy_after, o.finished, o.req_cycles);
    end
  endtask

  task automatic test_reset_mid_req();
    int dones = 0;
    icode = 4'h5; valE = 64'h50; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL mid_req_start got mem_req=%b exp 1", mem_req);
    end
    step(); step();
    reset = 1'b1; start = 1'b1; mem_ack = 1'b1; mem_rdata = 64'h1234;
    step();
    reset = 1'b0; start = 1'b0; mem_ack = 1'b0;
    exp_valm = 64'd0;
    checks++;
    if ({busy, done, mem_req, mem_we, dmem_error} !== 5'b0 || {mem_addr, mem_wdata, valM} !== 192'd0) begin
      errors++; $display("FAIL mid_req_reset got ctrl=%b addr=%h valM=%h exp 0", {busy, done, mem_req, mem_we, dmem_error}, mem_addr, valM);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (done === 1'b1 || busy !== 1'b0) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL mid_req_after got %0d active cycles exp 0", dones);
    end
  endtask

  task automatic test_random();
    obs_t o;
    int kind, ack_at, exp_req, exp_lat;
    logic [63:0] a, b, e, p, rdata, m_addr, m_wdata;
    logic [3:0] ic;
    bit bad, exp_err;
    for (int n = 0; n < 40; n++) begin
      ic = 4'($urandom_range(0, 15));
      a = {$urandom, $urandom}; p = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      b = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1100));
      e = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1100));
      ack_at = $urandom_range(0, 20);
      model(ic, a, b, e, p, kind, m_addr, m_wdata, bad);
      exp_req = (kind == 0 || bad) ? 0 : ((ack_at < int'(TIMEOUT)) ? ack_at + 1 : int'(TIMEOUT));
      exp_lat = (exp_req == 0) ? 1 : exp_req + 1;
      exp_err = bad || (exp_req != 0 && ack_at >= int'(TIMEOUT));
      if (kind == 1 && exp_req != 0 && ack_at < int'(TIMEOUT)) exp_valm = rdata;
      run_op(ic, a, b, e, p, ack_at, rdata, 1'b0, 1'b0, o);
      checks++;
      if (o.req_cycles != exp_req || o.done_lat != exp_lat || o.done_cnt != 1) begin
        errors++; $display("FAIL rand%0d timing ic=%h got req=%0d lat=%0d cnt=%0d exp %0d/%0d/1", n, ic, o.req_cycles, o.done_lat, o.done_cnt, exp_req, exp_lat);
      end
      if (exp_req != 0) begin
        checks++;
        if (o.addr !== m_addr || o.we !== (kind == 2) || !o.stable || (kind == 2 && o.wdata !== m_wdata)) begin
          errors++; $display("FAIL rand%0d req ic=%h got addr=%h we=%b wdata=%h exp %h/%0d/%h", n, ic, o.addr, o.we, o.wdata, m_addr, kind == 2, m_wdata);
        end
      end
      checks++;
      if (o.err !== exp_err || o.valm !== exp_valm || o.busy_after !== 1'b0 || o.err_after !== exp_err) begin
        errors++; $display("FAIL rand%0d result ic=%h got err=%b valM=%h busy=%b exp %b/%h/0", n, ic, o.err, o.valm, o.busy_after, exp_err, exp_valm);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; icode = 4'h0;
    valA = '0; valB = '0; valE = '0; valP = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    test_reset();
    test_mrmovq();
    test_call();
    test_popq();
    test_bad_addr();
    test_timeout();
    test_ack_ignored();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
